// File: rtl/padder_arbiter_pkg.sv
// Shared constants and pipeline entry types for the round-robin arbiter that
// fronts the 26-bit parallel-prefix adder.
package padder_arbiter_pkg;

  localparam int WIDTH = 26;
  localparam int NREQ  = 4;
  localparam int ID_W  = $clog2(NREQ);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [ID_W-1:0]  id;
  } s1_entry_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [ID_W-1:0]  id;
  } s2_entry_t;

endpackage

// File: rtl/padder_arbiter_padder26.sv
// 26-bit Kogge-Stone parallel-prefix adder with carry-in; purely combinational.
module padder26 (
  input  logic [25:0] a,
  input  logic [25:0] b,
  input  logic        cin,
  output logic [25:0] sum,
  output logic        cout
);

  localparam int N      = 26;
  localparam int LEVELS = 5;

  logic [N-1:0] prop_bit;
  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N-1:0] carry;

  // NOTE: every variable written here is assigned first on every pass, so no latch is inferred.
  always_comb begin
    prop_bit = a ^ b;
    gen      = a & b;
    prop     = prop_bit;
    // Fold the carry-in into bit 0 so the prefix tree yields true carries directly.
    gen[0]   = gen[0] | (prop[0] & cin);
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      // Walk downward so each bit combines with its neighbour's previous-level value.
      for (int i = N - 1; i >= (1 << lvl); i--) begin
        gen[i]  = gen[i] | (prop[i] & gen[i - (1 << lvl)]);
        prop[i] = prop[i] & prop[i - (1 << lvl)];
      end
    end
    carry = {gen[N-2:0], cin};
    sum   = prop_bit ^ carry;
    cout  = gen[N-1];
  end

endmodule

// File: rtl/padder_arbiter.sv
// Round-robin arbiter feeding a shared prefix adder through a two-stage
// (operand / result) valid-ready pipeline, with a consumed-result counter.
module padder_arbiter
  import padder_arbiter_pkg::s1_entry_t, padder_arbiter_pkg::s2_entry_t;
#(
  parameter int  WIDTH = padder_arbiter_pkg::WIDTH,
  parameter int  NREQ  = padder_arbiter_pkg::NREQ,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic [ID_W-1:0]       res_id,
  output logic [15:0]           op_count
);

  s1_entry_t        s1;
  s2_entry_t        s2;
  logic             s1_valid;
  logic             s2_valid;
  logic [ID_W-1:0]  rr_ptr;
  logic [15:0]      op_cnt;

  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic             s2_load;
  logic             s1_can_accept;
  logic             accept;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign s2_load       = s1_valid && (!s2_valid || res_ready);
  assign s1_can_accept = !s1_valid || s2_load;

  // Search starts one past the last winner; NREQ is a power of two so the index wraps by truncation.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = rr_ptr + ID_W'(k);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = idx;
        found      = 1'b1;
      end
    end
  end

  assign req_ready = (rst_n && s1_can_accept) ? grant : '0;
  assign accept    = |req_ready;

  padder26 u_padder26 (
    .a    (s1.a),
    .b    (s1.b),
    .cin  (s1.cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2       <= '0;
      rr_ptr   <= ID_W'(NREQ - 1);
      op_cnt   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        rr_ptr   <= gnt_id;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2       <= '{sum: add_sum, cout: add_cout, id: s1.id};
        s2_valid <= 1'b1;
      end else if (res_ready) begin
        s2_valid <= 1'b0;
      end

      if (s2_valid && res_ready) op_cnt <= op_cnt + 16'd1;
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid, so it needs no reset and only loads on an accept.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      s1 <= '{a:   req_a[int'(gnt_id)*WIDTH +: WIDTH],
              b:   req_b[int'(gnt_id)*WIDTH +: WIDTH],
              cin: req_cin[gnt_id],
              id:  gnt_id};
    end
  end

  assign res_valid = s2_valid;
  assign res_sum   = s2.sum;
  assign res_cout  = s2.cout;
  assign res_id    = s2.id;
  assign op_count  = op_cnt;

endmodule
